// File: rtl/sort_pkg.sv
// Shared types and constants for the bitonic sorter stages.
package sort_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefIndex = 8;
  localparam int unsigned MaxWidth = 64;

  typedef enum logic {FILL, EMIT} state_e;

  // All-ones pad word of the requested width. It sorts to the high end of any pair.
  function automatic logic [MaxWidth-1:0] pad_word(input int unsigned w);
    logic [MaxWidth-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/max_min_2.sv
// Two-input unsigned compare-swap. When up is set, o_x takes the min; otherwise o_x takes the max.
module max_min_2 #(
  parameter int unsigned width = 8,
  parameter bit          up    = 1'b1
) (
  input  logic [width-1:0] i_a,
  input  logic [width-1:0] i_b,
  output logic [width-1:0] o_x,
  output logic [width-1:0] o_y
);

  logic w_swap;

  // Equal values never swap, so they pass through unchanged.
  assign w_swap = up ? (i_a > i_b) : (i_a < i_b);
  assign o_x    = w_swap ? i_b : i_a;
  assign o_y    = w_swap ? i_a : i_b;

endmodule

// File: rtl/step1_loader.sv
// Bitonic sorter stage 1: gathers a serial stream into padded frames and sorts each pair
// in alternating direction. The result is a bitonic sequence in every group of four.
module step1_loader
  import sort_pkg::*;
#(
  parameter int unsigned width = DefWidth,
  parameter int unsigned index = DefIndex
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [width-1:0]                 in_data,
  input  logic                             in_last,
  output logic [0:index-1][width-1:0]      step1_data,
  output logic                             frame_valid,
  output logic [$clog2(index+1)-1:0]       pad_count
);

  localparam int unsigned CntW = $clog2(index);
  localparam int unsigned PcW  = $clog2(index + 1);
  localparam logic [width-1:0] PAD = width'(pad_word(width));

  state_e                        r_state;
  logic   [CntW-1:0]             r_count;
  logic   [PcW-1:0]              r_pad;
  logic   [0:index-1][width-1:0] r_buf;
  logic   [0:index-1][width-1:0] w_sorted;
  logic                          w_accept;
  logic                          w_close;

  assign in_ready = rst && (r_state == FILL);
  assign w_accept = in_valid && in_ready;
  assign w_close  = w_accept && (in_last || (r_count == CntW'(index - 1)));

  for (genvar k = 0; k < index / 2; k++) begin : g_pair
    max_min_2 #(
      .width (width),
      .up    ((k % 2) == 0)
    ) u_mm (
      .i_a (r_buf[2*k]),
      .i_b (r_buf[2*k+1]),
      .o_x (w_sorted[2*k]),
      .o_y (w_sorted[2*k+1])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FILL;
      r_count     <= '0;
      r_pad       <= '0;
      r_buf       <= '0;
      step1_data  <= '0;
      frame_valid <= 1'b0;
      pad_count   <= '0;
    end else begin
      frame_valid <= 1'b0;
      unique case (r_state)
        FILL: begin
          if (w_accept) begin
            // Slots past the closing element are padded on the same edge.
            for (int unsigned i = 0; i < index; i++) begin
              if (CntW'(i) == r_count) begin
                r_buf[i] <= in_data;
              end else if (w_close && (CntW'(i) > r_count)) begin
                r_buf[i] <= PAD;
              end
            end
            r_count <= r_count + CntW'(1);
            if (w_close) begin
              r_pad   <= PcW'(index - 1) - PcW'(r_count);
              r_state <= EMIT;
            end
          end
        end
        EMIT: begin
          step1_data  <= w_sorted;
          frame_valid <= 1'b1;
          pad_count   <= r_pad;
          r_count     <= '0;
          r_state     <= FILL;
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_step1_loader.sv
// Scoreboard bench for step1_loader: randomized and directed frames are checked against a
// frame-level reference model, including latency, in_ready behaviour and reset.
module tb_step1_loader;

  localparam int unsigned W = 8;
  localparam int unsigned N = 8;

  typedef struct {
    logic [0:N-1][W-1:0] d;
    int unsigned         pad;
    int unsigned         cyc;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_data;
  logic                  in_last;
  logic [0:N-1][W-1:0]   step1_data;
  logic                  frame_valid;
  logic [$clog2(N+1)-1:0] pad_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  int unsigned run   = 0;
  exp_t        sb[$];
  logic [W-1:0] cur[$];

  step1_loader #(
    .width (W),
    .index (N)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .step1_data  (step1_data),
    .frame_valid (frame_valid),
    .pad_count   (pad_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint unsigned act,
                                input longint unsigned req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: pad to N with all-ones, then sort pair k ascending if k even, descending if odd.
  function automatic void model_accept(input logic [W-1:0] d, input logic l,
                                       input int unsigned vis_cyc);
    exp_t        e;
    logic [W-1:0] s[N];
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    cur.push_back(d);
    if (l || cur.size() == N) begin
      for (int i = 0; i < N; i++) s[i] = (i < cur.size()) ? cur[i] : {W{1'b1}};
      for (int k = 0; k < N / 2; k++) begin
        lo = (s[2*k] < s[2*k+1]) ? s[2*k] : s[2*k+1];
        hi = (s[2*k] < s[2*k+1]) ? s[2*k+1] : s[2*k];
        e.d[2*k]   = (k % 2 == 0) ? lo : hi;
        e.d[2*k+1] = (k % 2 == 0) ? hi : lo;
      end
      e.pad = N - cur.size();
      e.cyc = vis_cyc;
      sb.push_back(e);
      cur.delete();
    end
  endfunction

  // Holds in_valid until the element is taken; in_valid is left high afterwards.
  task automatic send(input logic [W-1:0] d, input logic l);
    bit acc = 0;
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!acc) begin
      if (in_ready) begin
        acc = 1;
        model_accept(d, l, cyc + 2);
      end
      @(posedge clk);
      if (!acc) begin
        @(negedge clk);
        guard++;
        if (guard > 20) begin
          check("accept_timeout", 0, 1);
          acc = 1;
        end
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"}, (step1_data == '0) ? 0 : 1, 0);
    check({tag, "_fv"}, frame_valid, 0);
    check({tag, "_pad"}, pad_count, 0);
    check({tag, "_rdy"}, in_ready, 0);
  endtask

  // Monitor: every frame_valid pulse must match the oldest expected frame and its cycle.
  always @(negedge clk) begin
    if (frame_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_frame", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("frame_data", step1_data, e.d);
        check("pad_count", pad_count, e.pad);
        check("frame_cycle", cyc, e.cyc);
      end
    end
  end

  // in_ready may only drop for the single EMIT cycle.
  always @(negedge clk) begin
    if (!rst) begin
      run = 0;
    end else if (!in_ready) begin
      run++;
    end else begin
      if (run != 0) check("ready_low_len", run, 1);
      run = 0;
    end
  end

  logic [W-1:0] t1[N];

  initial begin
    int unsigned len;
    int unsigned wait_n;
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Full frame, no in_last
    t1 = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd7, 8'd0, 8'd200};
    for (int i = 0; i < N; i++) send(t1[i], 1'b0);
    idle(3);
    // Short frame closed by in_last
    send(8'd4, 1'b0); send(8'd2, 1'b0); send(8'd6, 1'b1);
    idle(3);
    // in_last on the first element
    send(8'd10, 1'b1);
    idle(3);
    // Last on the 8th element gives pad_count 0
    for (int i = 0; i < N; i++) send(8'(i * 30), i == N - 1);
    idle(3);

    // Reset mid-frame: partial frame discarded, outputs cleared at once
    send(8'd11, 1'b0); send(8'd12, 1'b0); send(8'd13, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    cur.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) send(8'(100 - i * 7), 1'b0);
    idle(3);

    // Reset landing in EMIT suppresses that frame's pulse
    for (int i = 0; i < N; i++) send(8'(i + 40), 1'b0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    void'(sb.pop_back());
    #1;
    check_reset_outputs("emitrst");
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // Three back-to-back full frames, in_valid held high
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) send(8'($urandom), 1'b0);
    idle(3);

    // Randomized frames with gaps and early in_last
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, N);
      for (int unsigned i = 0; i < len; i++) begin
        send(8'($urandom), (i == len - 1) && (len < N || $urandom_range(0, 1) == 1));
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    idle(2);

    wait_n = 0;
    while (sb.size() != 0 && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
